// File: rtl/poly_sound_gen_if.sv
// Control/sequencer and DAC-side bus of the polyphonic sound generator.
// The master side drives strobe and config; the slave (generator) returns mixed samples and status.
interface poly_sound_gen_if #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned PHASE_W  = 16
);
  logic                       sample_strobe;
  logic                       cfg_we;
  logic [3:0]                 cfg_voice;
  logic [PHASE_W-1:0]         cfg_freq;
  logic [3:0]                 cfg_vol;
  logic [1:0]                 cfg_wave;
  logic [1:0]                 cfg_pan;
  logic                       cfg_sync;
  logic signed [SAMPLE_W-1:0] left_sample;
  logic signed [SAMPLE_W-1:0] right_sample;
  logic                       sample_valid;
  logic                       clip;
  logic                       overrun;

  modport master (
    output sample_strobe, cfg_we, cfg_voice, cfg_freq, cfg_vol, cfg_wave, cfg_pan, cfg_sync,
    input  left_sample, right_sample, sample_valid, clip, overrun
  );

  modport slave (
    input  sample_strobe, cfg_we, cfg_voice, cfg_freq, cfg_vol, cfg_wave, cfg_pan, cfg_sync,
    output left_sample, right_sample, sample_valid, clip, overrun
  );
endinterface

// File: rtl/poly_sound_gen.sv
// Time-multiplexed polyphonic sound generator: one voice per cycle is accumulated into
// saturated stereo samples, producing one frame per accepted sample strobe.
module poly_sound_gen #(
  parameter int unsigned VOICES   = 4,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned PHASE_W  = 16
) (
  input logic             clk,
  input logic             rst,
  poly_sound_gen_if.slave bus
);

  localparam int unsigned VIDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned VSLOTS = 1 << VIDX_W;
  localparam int unsigned ACC_W  = SAMPLE_W + 4;
  localparam int unsigned SHIFT  = SAMPLE_W - 12;
  localparam logic [20:0] LFSR_SEED = 21'h155555;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{5{1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{5{1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  typedef struct packed {
    logic [PHASE_W-1:0] freq;
    logic [3:0]         vol;
    logic [1:0]         wave;
    logic [1:0]         pan;
    logic               sync;
  } voice_cfg_t;

  state_t                    state_q, state_d;
  logic                      start_frame, acc_en, out_en, drop;
  voice_cfg_t                shadow [VSLOTS];
  voice_cfg_t                active [VSLOTS];
  logic [PHASE_W-1:0]        phase  [VSLOTS];
  logic [VIDX_W-1:0]         voice_idx;
  logic signed [ACC_W-1:0]   acc_l, acc_r;
  logic [20:0]               lfsr;

  logic                      cfg_hit;
  logic [VIDX_W-1:0]         cfg_idx;
  voice_cfg_t                cfg_wr;

  voice_cfg_t                cur;
  logic [PHASE_W-1:0]        p;
  logic [7:0]                h, t;
  logic signed [7:0]         w;
  logic signed [11:0]        w_ext, vol_ext, c;
  logic signed [ACC_W-1:0]   contrib;

  logic [SAMPLE_W-1:0]       sat_l, sat_r;
  logic                      clip_l, clip_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and frame control strobes
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    acc_en      = 1'b0;
    out_en      = 1'b0;
    drop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sample_strobe) begin
          start_frame = 1'b1;
          state_d     = ACC;
        end
      end
      ACC: begin
        acc_en = 1'b1;
        drop   = bus.sample_strobe;
        if (voice_idx == VIDX_W'(VOICES - 1)) state_d = OUT;
      end
      OUT: begin
        out_en  = 1'b1;
        drop    = bus.sample_strobe;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Config port decode
  always_comb begin
    cfg_hit = bus.cfg_we && (32'(bus.cfg_voice) < VOICES);
    cfg_idx = bus.cfg_voice[VIDX_W-1:0];
    cfg_wr  = '{freq: bus.cfg_freq, vol: bus.cfg_vol, wave: bus.cfg_wave,
                pan: bus.cfg_pan, sync: bus.cfg_sync};
  end

  // Waveform and scaled contribution of the voice being processed
  always_comb begin
    cur = active[voice_idx];
    p   = cur.sync ? '0 : phase[voice_idx];
    h   = p[PHASE_W-1 -: 8];
    t   = p[PHASE_W-2 -: 8];
    w   = '0;
    case (cur.wave)
      2'd0:    w = h ^ 8'h80;
      2'd1:    w = p[PHASE_W-1] ? 8'h80 : 8'h7f;
      2'd2:    w = (p[PHASE_W-1] ? ~t : t) ^ 8'h80;
      default: w = lfsr[7:0];
    endcase
    w_ext   = 12'(w);
    vol_ext = 12'({1'b0, cur.vol});
    c       = w_ext * vol_ext;
    contrib = ACC_W'(c) <<< SHIFT;
  end

  // Output saturation
  always_comb begin
    clip_l = (acc_l > SAT_MAX) || (acc_l < SAT_MIN);
    clip_r = (acc_r > SAT_MAX) || (acc_r < SAT_MIN);
    sat_l  = acc_l[SAMPLE_W-1:0];
    sat_r  = acc_r[SAMPLE_W-1:0];
    if (acc_l > SAT_MAX) sat_l = SAT_MAX[SAMPLE_W-1:0];
    if (acc_l < SAT_MIN) sat_l = SAT_MIN[SAMPLE_W-1:0];
    if (acc_r > SAT_MAX) sat_r = SAT_MAX[SAMPLE_W-1:0];
    if (acc_r < SAT_MIN) sat_r = SAT_MIN[SAMPLE_W-1:0];
  end

  // Voice state, accumulators and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VSLOTS; v++) begin
        shadow[v] <= '0;
        active[v] <= '0;
        phase[v]  <= '0;
      end
      voice_idx        <= '0;
      acc_l            <= '0;
      acc_r            <= '0;
      lfsr             <= LFSR_SEED;
      bus.left_sample  <= '0;
      bus.right_sample <= '0;
      bus.sample_valid <= 1'b0;
      bus.clip         <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      bus.clip         <= 1'b0;
      if (drop) bus.overrun <= 1'b1;

      if (start_frame) begin
        for (int v = 0; v < VSLOTS; v++) begin
          active[v]      <= shadow[v];
          shadow[v].sync <= 1'b0;
        end
        acc_l     <= '0;
        acc_r     <= '0;
        voice_idx <= '0;
      end

      // Issued after the commit so a same-cycle write survives into the next frame
      if (cfg_hit) shadow[cfg_idx] <= cfg_wr;

      if (acc_en) begin
        if (cur.pan[1]) acc_l <= acc_l + contrib;
        if (cur.pan[0]) acc_r <= acc_r + contrib;
        phase[voice_idx] <= p + cur.freq;
        voice_idx        <= voice_idx + 1'b1;
      end

      if (out_en) begin
        bus.left_sample  <= sat_l;
        bus.right_sample <= sat_r;
        bus.sample_valid <= 1'b1;
        bus.clip         <= clip_l || clip_r;
        lfsr             <= {lfsr[19:0], lfsr[20] ^ lfsr[19]};
      end
    end
  end

endmodule

// File: tb/tb_poly_sound_gen.sv
// Directed bench for poly_sound_gen: a table of single-frame vectors plus hand-written
// sequences for overrun, config commit timing, sync and mid-frame reset.
module tb_poly_sound_gen;

  localparam int unsigned VOICES   = 4;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned PHASE_W  = 16;
  localparam int          NV       = 16;

  typedef struct {
    bit          do_rst;
    logic [3:0]  mask;
    logic [15:0] freq;
    logic [3:0]  vol;
    logic [1:0]  wave;
    logic [1:0]  pan;
    int          exp_l;
    int          exp_r;
    int          exp_clip;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs [NV];

  poly_sound_gen_if #(.SAMPLE_W(SAMPLE_W), .PHASE_W(PHASE_W)) bus ();

  poly_sound_gen #(.VOICES(VOICES), .SAMPLE_W(SAMPLE_W), .PHASE_W(PHASE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_cfg(input int v, input logic [15:0] f, input logic [3:0] vol,
                           input logic [1:0] wave, input logic [1:0] pan, input logic sync);
    bus.cfg_voice = 4'(v);
    bus.cfg_freq  = f;
    bus.cfg_vol   = vol;
    bus.cfg_wave  = wave;
    bus.cfg_pan   = pan;
    bus.cfg_sync  = sync;
    bus.cfg_we    = 1'b1;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.sample_valid) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic run_frame(output int l, output int r, output int c, output int lat);
    bus.sample_strobe = 1'b1;
    tick();
    bus.sample_strobe = 1'b0;
    wait_valid(lat);
    l = int'($signed(bus.left_sample));
    r = int'($signed(bus.right_sample));
    c = int'(bus.clip);
  endtask

  initial begin
    int l, r, c, lat, nvalid, first;
    n_checks = 0;
    n_fail   = 0;
    rst               = 1'b1;
    bus.sample_strobe = 1'b0;
    bus.cfg_we        = 1'b0;
    bus.cfg_voice     = '0;
    bus.cfg_freq      = '0;
    bus.cfg_vol       = '0;
    bus.cfg_wave      = '0;
    bus.cfg_pan       = '0;
    bus.cfg_sync      = 1'b0;

    // {rst, voice mask, freq, vol, wave, pan, left, right, clip}; mask 0 = no write
    vecs[0]  = '{1, 4'h1, 16'h0000, 4'd15, 2'd1, 2'b11,  30480,  30480, 0};
    vecs[1]  = '{1, 4'hF, 16'h0000, 4'd15, 2'd1, 2'b11,  32767,  32767, 1};
    vecs[2]  = '{0, 4'hE, 16'h0000, 4'd0,  2'd1, 2'b11,  30480,  30480, 0};
    vecs[3]  = '{1, 4'hF, 16'h0000, 4'd15, 2'd0, 2'b11, -32768, -32768, 1};
    vecs[4]  = '{1, 4'h1, 16'h0000, 4'd15, 2'd1, 2'b00,      0,      0, 0};
    vecs[5]  = '{1, 4'h1, 16'h4000, 4'd1,  2'd0, 2'b10,  -2048,      0, 0};
    vecs[6]  = '{0, 4'h0, 16'h0000, 4'd0,  2'd0, 2'b00,  -1024,      0, 0};
    vecs[7]  = '{0, 4'h0, 16'h0000, 4'd0,  2'd0, 2'b00,      0,      0, 0};
    vecs[8]  = '{0, 4'h0, 16'h0000, 4'd0,  2'd0, 2'b00,   1024,      0, 0};
    vecs[9]  = '{0, 4'h0, 16'h0000, 4'd0,  2'd0, 2'b00,  -2048,      0, 0};
    vecs[10] = '{1, 4'h1, 16'h4000, 4'd1,  2'd2, 2'b01,      0,  -2048, 0};
    vecs[11] = '{0, 4'h0, 16'h0000, 4'd0,  2'd0, 2'b00,      0,      0, 0};
    vecs[12] = '{0, 4'h0, 16'h0000, 4'd0,  2'd0, 2'b00,      0,   2032, 0};
    vecs[13] = '{0, 4'h0, 16'h0000, 4'd0,  2'd0, 2'b00,      0,    -16, 0};
    vecs[14] = '{1, 4'h1, 16'h0000, 4'd1,  2'd3, 2'b11,   1360,   1360, 0};
    vecs[15] = '{0, 4'h0, 16'h0000, 4'd0,  2'd0, 2'b00,  -1360,  -1360, 0};

    do_reset();
    check("reset left", int'($signed(bus.left_sample)), 0);
    check("reset right", int'($signed(bus.right_sample)), 0);
    check("reset valid", int'(bus.sample_valid), 0);
    check("reset clip", int'(bus.clip), 0);
    check("reset overrun", int'(bus.overrun), 0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_rst) do_reset();
      for (int v = 0; v < VOICES; v++)
        if (vecs[i].mask[v])
          write_cfg(v, vecs[i].freq, vecs[i].vol, vecs[i].wave, vecs[i].pan, 1'b0);
      run_frame(l, r, c, lat);
      check($sformatf("vec%0d latency", i), lat, VOICES + 1);
      check($sformatf("vec%0d left", i), l, vecs[i].exp_l);
      check($sformatf("vec%0d right", i), r, vecs[i].exp_r);
      check($sformatf("vec%0d clip", i), c, vecs[i].exp_clip);
    end

    // Overrun: second strobe lands during ACC
    do_reset();
    write_cfg(0, 16'h0000, 4'd15, 2'd1, 2'b11, 1'b0);
    bus.sample_strobe = 1'b1;
    tick();
    bus.sample_strobe = 1'b0;
    tick();
    bus.sample_strobe = 1'b1;
    tick();
    bus.sample_strobe = 1'b0;
    nvalid = 0;
    first  = -1;
    for (int k = 3; k <= 15; k++) begin
      tick();
      if (bus.sample_valid) begin
        nvalid++;
        if (first < 0) first = k;
      end
    end
    check("overrun valid count", nvalid, 1);
    check("overrun valid edge", first, VOICES + 1);
    check("overrun flag", int'(bus.overrun), 1);
    run_frame(l, r, c, lat);
    check("overrun sticky", int'(bus.overrun), 1);
    check("overrun next frame", l, 30480);
    do_reset();
    check("overrun cleared", int'(bus.overrun), 0);

    // Config commit: write during ACC affects only the following frame
    do_reset();
    write_cfg(0, 16'h0000, 4'd1, 2'd1, 2'b11, 1'b0);
    bus.sample_strobe = 1'b1;
    tick();
    bus.sample_strobe = 1'b0;
    tick();
    write_cfg(0, 16'h0000, 4'd15, 2'd1, 2'b11, 1'b0);
    wait_valid(lat);
    check("commit frame N", int'($signed(bus.left_sample)), 2032);
    run_frame(l, r, c, lat);
    check("commit frame N+1", l, 30480);
    write_cfg(7, 16'h0000, 4'd0, 2'd0, 2'b00, 1'b0);
    run_frame(l, r, c, lat);
    check("ignored voice 7", l, 30480);
    bus.cfg_voice     = 4'd0;
    bus.cfg_freq      = 16'h0000;
    bus.cfg_vol       = 4'd3;
    bus.cfg_wave      = 2'd1;
    bus.cfg_pan       = 2'b11;
    bus.cfg_sync      = 1'b0;
    bus.cfg_we        = 1'b1;
    bus.sample_strobe = 1'b1;
    tick();
    bus.cfg_we        = 1'b0;
    bus.sample_strobe = 1'b0;
    wait_valid(lat);
    check("same-cycle write frame", int'($signed(bus.left_sample)), 30480);
    run_frame(l, r, c, lat);
    check("same-cycle write next", l, 6096);

    // Sync zeroes the saw phase for one frame only
    do_reset();
    write_cfg(0, 16'h4000, 4'd1, 2'd0, 2'b10, 1'b0);
    run_frame(l, r, c, lat);
    check("sync pre frame 0", l, -2048);
    run_frame(l, r, c, lat);
    check("sync pre frame 1", l, -1024);
    write_cfg(0, 16'h4000, 4'd1, 2'd0, 2'b10, 1'b1);
    run_frame(l, r, c, lat);
    check("sync frame", l, -2048);
    run_frame(l, r, c, lat);
    check("sync after", l, -1024);

    // Mid-frame reset aborts the frame and clears phases
    do_reset();
    write_cfg(0, 16'h4000, 4'd1, 2'd0, 2'b10, 1'b0);
    run_frame(l, r, c, lat);
    check("midrst pre frame", l, -2048);
    bus.sample_strobe = 1'b1;
    tick();
    bus.sample_strobe = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.sample_valid) nvalid++;
    end
    check("midrst no valid", nvalid, 0);
    check("midrst left", int'($signed(bus.left_sample)), 0);
    check("midrst right", int'($signed(bus.right_sample)), 0);
    run_frame(l, r, c, lat);
    check("midrst golden latency", lat, VOICES + 1);
    check("midrst golden left", l, 0);
    check("midrst golden right", r, 0);
    write_cfg(0, 16'h4000, 4'd1, 2'd0, 2'b10, 1'b0);
    run_frame(l, r, c, lat);
    check("midrst phase cleared", l, -2048);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_sound_gen.md
# poly_sound_gen

Parametrised, time-multiplexed polyphonic sound generator. It runs VOICES independently programmable voices, each with its own phase accumulator, waveform, volume and stereo pan. All voices are mixed into saturated signed left/right samples, one frame per accepted `sample_strobe`. It sits between the control/sequencer logic, which drives the config port, and the audio DAC serializer, which consumes `left_sample`/`right_sample` on `sample_valid`.

## Interface
- `VOICES`, 4: number of voices, 1..16.
- `SAMPLE_W`, 16: output sample width, signed two's complement, >= 12.
- `PHASE_W`, 16: phase accumulator and frequency word width, >= 10.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `sample_strobe` in 1: one-cycle request to produce the next frame.
- `cfg_we` in 1: config write strobe.
- `cfg_voice` in 4: target voice index.
- `cfg_freq` in PHASE_W: phase increment per frame.
- `cfg_vol` in 4: volume, unsigned 0..15.
- `cfg_wave` in 2: waveform, 0 saw, 1 square, 2 triangle, 3 noise.
- `cfg_pan` in 2: {left_en, right_en}.
- `cfg_sync` in 1: zero this voice's phase at the next frame start.
- `left_sample` out SAMPLE_W: mixed left sample, signed.
- `right_sample` out SAMPLE_W: mixed right sample, signed.
- `sample_valid` out 1: one-cycle pulse when the samples update.
- `clip` out 1: high with `sample_valid` if either channel saturated in that frame.
- `overrun` out 1: sticky; set when a strobe is dropped. Cleared only by `rst`.

## Operation
- Config path:
  - The config port writes per-voice shadow registers (freq, vol, wave, pan, sync) on `cfg_we`.
  - A `cfg_voice` value >= VOICES is ignored.
  - At frame start (strobe accepted), shadow registers are copied to the active set and the shadow sync bits clear.
  - A write in the same cycle as frame start lands in shadow only. It takes effect from the next frame.
- FSM has three states: IDLE, ACC, OUT.
  - IDLE: when `sample_strobe`=1, commit config, clear both accumulators, set `voice_idx`=0, go to ACC.
  - ACC: process voice `voice_idx` in one cycle. Leave at `voice_idx`=VOICES-1, moving to OUT.
  - OUT: register saturated outputs, pulse `sample_valid` (and `clip` if applicable), return to IDLE.
  - `sample_strobe` seen in ACC or OUT is dropped and sets `overrun`.
- Per-voice processing in ACC:
  - Let p be the voice's current phase; if the active sync bit is set, p=0.
  - Let h = p[PHASE_W-1 -: 8] and t = p[PHASE_W-2 -: 8].
  - Compute w as signed 8-bit:
    - saw: h ^ 8'h80.
    - square: p MSB=0 gives +127, else -128.
    - triangle: (p MSB ? ~t : t) ^ 8'h80.
    - noise: lfsr[7:0].
  - Contribution c = (w * vol), signed 12-bit, shifted left by SAMPLE_W-12.
  - Add c to the left accumulator if left_en, and to the right accumulator if right_en.
  - Store phase = p + freq, modulo 2^PHASE_W. The sample uses the pre-increment phase.
- Accumulators are SAMPLE_W+4 bits signed. In OUT, each is saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- Noise LFSR:
  - 21 bits, seed 21'h155555.
  - Shift left with bit0 = lfsr[20]^lfsr[19].
  - Advances once per accepted frame, after all voices have used the same value.

## Timing
- Strobe accepted in cycle 0 means voice i is processed in cycle i+1 and `sample_valid` is high in cycle VOICES+1.
- Strobe-to-valid latency is VOICES+1 cycles. Minimum strobe spacing without overrun is VOICES+2 cycles.
- `left_sample`/`right_sample` hold their value between `sample_valid` pulses.
- `rst` puts the design in this state:
  - all outputs 0;
  - state IDLE;
  - all phases, freq, vol, wave, pan and sync (active and shadow) 0;
  - LFSR at its seed; `overrun` 0.
- `rst` mid-frame aborts the frame: no `sample_valid`, and phases are reset.
- `rst` has priority over `sample_strobe` and `cfg_we` in the same cycle.

## Test plan
- Square output: voice0 square, vol 15, pan 2'b11, freq 0; strobe at cycle 0 -> `sample_valid` at cycle 5 (VOICES=4) with left=right=30480, `clip`=0.
- Saturation: all 4 voices square, vol 15, pan 2'b11; strobe -> left=right=32767, `clip`=1. Same setup with vol 0 on voices 1-3 -> 30480, `clip`=0.
- Saw sweep: voice0 saw, vol 1, freq 16'h4000, pan 2'b10; four frames -> left = -2048, -1024, 0, 1024, then wraps to -2048; right=0 throughout.
- Overrun: strobe at cycle 0 and again at cycle 2 -> one `sample_valid` at cycle 5, `overrun`=1 and stays 1 until `rst`.
- Config commit: write voice0 vol 15 during ACC of frame N -> frame N output unchanged, frame N+1 uses vol 15. A write with `cfg_voice`=7 has no effect. `cfg_sync` returns the saw to -128 on the next frame.
- Mid-frame reset: assert `rst` at cycle 2 of a frame -> no `sample_valid`, outputs 0. The next frame after release matches the post-reset golden values.
